// File: rtl/cbus_arbiter_if.sv
// Shared bus bundle around the arbiter: fetch and data request ports plus the downstream memory bus.
// The master modport is the arbiter's view (it masters the downstream bus); slave is the surroundings.
interface cbus_arbiter_if;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_data;

  logic        d_valid;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic [3:0]  d_strobe;
  logic [31:0] d_wdata;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [31:0] d_data;

  logic        m_valid;
  logic        m_is_instr;
  logic [31:0] m_addr;
  logic [1:0]  m_size;
  logic [3:0]  m_strobe;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_data;

  modport master (
    input  i_valid, i_addr,
    output i_addr_ok, i_data_ok, i_data,
    input  d_valid, d_addr, d_size, d_strobe, d_wdata,
    output d_addr_ok, d_data_ok, d_data,
    output m_valid, m_is_instr, m_addr, m_size, m_strobe, m_wdata,
    input  m_addr_ok, m_data_ok, m_data
  );

  modport slave (
    output i_valid, i_addr,
    input  i_addr_ok, i_data_ok, i_data,
    output d_valid, d_addr, d_size, d_strobe, d_wdata,
    input  d_addr_ok, d_data_ok, d_data,
    input  m_valid, m_is_instr, m_addr, m_size, m_strobe, m_wdata,
    output m_addr_ok, m_data_ok, m_data
  );
endinterface

// File: rtl/cbus_arbiter.sv
// Two-to-one fetch/data arbiter for the shared memory bus: data wins by default, and a
// starvation counter forces an instruction grant after a bounded run of contested data grants.
module cbus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  cbus_arbiter_if.master       bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR_I = 3'd1,
    ADDR_D = 3'd2,
    DATA_I = 3'd3,
    DATA_D = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic grant_i, grant_d, addr_i, addr_d;

  // State and starvation counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Arbitration and transaction sequencing; grant is frozen outside IDLE
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (bus.d_valid && (!bus.i_valid || starve_q != LIMIT)) begin
          state_d = ADDR_D;
          if (bus.i_valid) begin
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + CNT_W'(1);
          end
        end else if (bus.i_valid) begin
          state_d  = ADDR_I;
          starve_d = '0;
        end
      end
      ADDR_I: begin
        if (bus.m_addr_ok) begin
          state_d = bus.m_data_ok ? IDLE : DATA_I;
        end
      end
      ADDR_D: begin
        if (bus.m_addr_ok) begin
          state_d = bus.m_data_ok ? IDLE : DATA_D;
        end
      end
      DATA_I: begin
        if (bus.m_data_ok) begin
          state_d = IDLE;
        end
      end
      DATA_D: begin
        if (bus.m_data_ok) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign addr_i  = (state_q == ADDR_I);
  assign addr_d  = (state_q == ADDR_D);
  assign grant_i = addr_i || (state_q == DATA_I);
  assign grant_d = addr_d || (state_q == DATA_D);

  // Downstream request: pass-through of the granted side during the address phase only
  assign bus.m_valid    = addr_i || addr_d;
  assign bus.m_is_instr = grant_i;
  assign bus.m_addr     = addr_i ? bus.i_addr : (addr_d ? bus.d_addr : 32'd0);
  assign bus.m_size     = addr_i ? 2'b10 : (addr_d ? bus.d_size : 2'b00);
  assign bus.m_strobe   = addr_d ? bus.d_strobe : 4'd0;
  assign bus.m_wdata    = addr_d ? bus.d_wdata : 32'd0;

  // Responses routed unbuffered to the granted side; IDLE swallows stray data_ok
  assign bus.i_addr_ok  = addr_i && bus.m_addr_ok;
  assign bus.i_data_ok  = grant_i && bus.m_data_ok;
  assign bus.i_data     = grant_i ? bus.m_data : 32'd0;
  assign bus.d_addr_ok  = addr_d && bus.m_addr_ok;
  assign bus.d_data_ok  = grant_d && bus.m_data_ok;
  assign bus.d_data     = grant_d ? bus.m_data : 32'd0;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: lone fetch, contested grant, starvation order,
// same-cycle completion, address stall and reset mid-transaction.
module tb_cbus_arbiter;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_pass;

  cbus_arbiter_if bus ();

  cbus_arbiter #(.STARVE_LIMIT(4)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Advance to just after the next rising edge; inputs change here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_mvalid(output int cycles);
    cycles = 0;
    while (!bus.m_valid && cycles < 8) begin
      step();
      settle();
      cycles++;
    end
  endtask

  logic exp_order [10];
  int   waited;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    resetn   = 1'b0;
    bus.i_valid = 1'b0; bus.i_addr = 32'd0;
    bus.d_valid = 1'b0; bus.d_addr = 32'd0; bus.d_size = 2'd0;
    bus.d_strobe = 4'd0; bus.d_wdata = 32'd0;
    bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b0; bus.m_data = 32'd0;
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    #12;
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_addr", bus.m_addr, 32'd0);
    check("rst_i_data_ok", 32'(bus.i_data_ok), 32'd0);
    step();
    resetn = 1'b1;

    // Lone fetch
    bus.i_valid = 1'b1; bus.i_addr = 32'hBFC0_0000;
    settle();
    check("fetch_latency_idle", 32'(bus.m_valid), 32'd0);
    step(); settle();
    check("fetch_m_valid", 32'(bus.m_valid), 32'd1);
    check("fetch_is_instr", 32'(bus.m_is_instr), 32'd1);
    check("fetch_m_addr", bus.m_addr, 32'hBFC0_0000);
    check("fetch_m_size", 32'(bus.m_size), 32'd2);
    check("fetch_m_strobe", 32'(bus.m_strobe), 32'd0);
    bus.m_addr_ok = 1'b1;
    settle();
    check("fetch_i_addr_ok", 32'(bus.i_addr_ok), 32'd1);
    check("fetch_d_addr_ok", 32'(bus.d_addr_ok), 32'd0);
    step();
    bus.m_addr_ok = 1'b0; bus.i_valid = 1'b0;
    settle();
    check("fetch_data_m_valid", 32'(bus.m_valid), 32'd0);
    check("fetch_data_addr_ok", 32'(bus.i_addr_ok), 32'd0);
    check("fetch_data_is_instr", 32'(bus.m_is_instr), 32'd1);
    step();
    bus.m_data_ok = 1'b1; bus.m_data = 32'h3C1D_0001;
    settle();
    check("fetch_i_data_ok", 32'(bus.i_data_ok), 32'd1);
    check("fetch_i_data", bus.i_data, 32'h3C1D_0001);
    check("fetch_d_data_ok", 32'(bus.d_data_ok), 32'd0);
    check("fetch_d_data", bus.d_data, 32'd0);
    step();
    bus.m_data_ok = 1'b0;
    settle();
    check("fetch_done_m_valid", 32'(bus.m_valid), 32'd0);
    check("fetch_done_data_ok", 32'(bus.i_data_ok), 32'd0);
    check("fetch_done_is_instr", 32'(bus.m_is_instr), 32'd0);

    // Contested: data first, then instruction
    bus.i_valid = 1'b1; bus.i_addr = 32'hBFC0_0004;
    bus.d_valid = 1'b1; bus.d_addr = 32'h8000_1000; bus.d_size = 2'd2;
    bus.d_strobe = 4'hF; bus.d_wdata = 32'hDEAD_BEEF;
    step(); settle();
    check("cont_is_instr", 32'(bus.m_is_instr), 32'd0);
    check("cont_m_addr", bus.m_addr, 32'h8000_1000);
    check("cont_m_strobe", 32'(bus.m_strobe), 32'hF);
    check("cont_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
    bus.m_addr_ok = 1'b1;
    settle();
    check("cont_d_addr_ok", 32'(bus.d_addr_ok), 32'd1);
    check("cont_i_addr_ok", 32'(bus.i_addr_ok), 32'd0);
    step();
    bus.m_addr_ok = 1'b0; bus.d_valid = 1'b0;
    step();
    bus.m_data_ok = 1'b1; bus.m_data = 32'h1234_5678;
    settle();
    check("cont_d_data_ok", 32'(bus.d_data_ok), 32'd1);
    check("cont_d_data", bus.d_data, 32'h1234_5678);
    check("cont_i_data", bus.i_data, 32'd0);
    step();
    bus.m_data_ok = 1'b0;
    settle();
    check("cont_idle_gap", 32'(bus.m_valid), 32'd0);
    step(); settle();
    check("cont_i_granted", 32'(bus.m_is_instr), 32'd1);
    check("cont_i_addr", bus.m_addr, 32'hBFC0_0004);
    bus.m_addr_ok = 1'b1; bus.m_data_ok = 1'b1; bus.m_data = 32'h0000_0042;
    settle();
    check("cont_i_data_ok", 32'(bus.i_data_ok), 32'd1);
    step();
    bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b0; bus.i_valid = 1'b0;

    // Starvation order with both requesters held high; each beat completes in its address cycle
    bus.i_valid = 1'b1; bus.d_valid = 1'b1; bus.d_strobe = 4'h0;
    for (int k = 0; k < 10; k++) begin
      settle();
      wait_mvalid(waited);
      check($sformatf("starve_grant_seen_%0d", k), 32'(bus.m_valid), 32'd1);
      if (k > 0) check($sformatf("starve_b2b_gap_%0d", k), 32'(waited), 32'd1);
      check($sformatf("starve_order_%0d", k), 32'(bus.m_is_instr), 32'(exp_order[k]));
      bus.m_addr_ok = 1'b1; bus.m_data_ok = 1'b1; bus.m_data = 32'(k);
      settle();
      if (!exp_order[k]) begin
        check($sformatf("same_cyc_d_addr_ok_%0d", k), 32'(bus.d_addr_ok), 32'd1);
        check($sformatf("same_cyc_d_data_ok_%0d", k), 32'(bus.d_data_ok), 32'd1);
      end else begin
        check($sformatf("same_cyc_i_data_ok_%0d", k), 32'(bus.i_data_ok), 32'd1);
      end
      step();
      bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b0;
      if (k == 9) begin
        bus.i_valid = 1'b0; bus.d_valid = 1'b0;
      end
      settle();
      check($sformatf("same_cyc_idle_%0d", k), 32'(bus.m_valid), 32'd0);
    end

    // Stall in ADDR_I while a data request appears
    bus.i_valid = 1'b1; bus.i_addr = 32'hBFC0_0010;
    step();
    bus.d_valid = 1'b1; bus.d_addr = 32'h8000_2000; bus.d_size = 2'd2;
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("stall_m_addr_%0d", k), bus.m_addr, 32'hBFC0_0010);
      check($sformatf("stall_is_instr_%0d", k), 32'(bus.m_is_instr), 32'd1);
      check($sformatf("stall_d_addr_ok_%0d", k), 32'(bus.d_addr_ok), 32'd0);
      step();
    end
    bus.m_addr_ok = 1'b1;
    settle();
    check("stall_i_addr_ok", 32'(bus.i_addr_ok), 32'd1);
    check("stall_d_addr_ok_end", 32'(bus.d_addr_ok), 32'd0);
    step();
    bus.m_addr_ok = 1'b0; bus.i_valid = 1'b0;
    bus.m_data_ok = 1'b1; bus.m_data = 32'hCAFE_0001;
    settle();
    check("stall_i_data", bus.i_data, 32'hCAFE_0001);
    step();
    bus.m_data_ok = 1'b0;
    step(); settle();
    check("stall_then_d", 32'(bus.m_valid & ~bus.m_is_instr), 32'd1);
    bus.m_addr_ok = 1'b1;
    step();
    bus.m_addr_ok = 1'b0; bus.d_valid = 1'b0;

    // Reset while in DATA_D
    resetn = 1'b0;
    bus.m_data_ok = 1'b1; bus.m_data = 32'h5555_AAAA;
    settle();
    check("rst_mid_d_data_ok", 32'(bus.d_data_ok), 32'd0);
    check("rst_mid_d_data", bus.d_data, 32'd0);
    check("rst_mid_is_instr", 32'(bus.m_is_instr), 32'd0);
    step();
    resetn = 1'b1;
    settle();
    check("late_data_ok_ignored", 32'(bus.d_data_ok), 32'd0);
    check("late_m_valid", 32'(bus.m_valid), 32'd0);
    step();
    bus.m_data_ok = 1'b0;
    bus.d_valid = 1'b1; bus.d_addr = 32'h8000_3002; bus.d_size = 2'd1; bus.d_strobe = 4'h0;
    step(); settle();
    check("post_rst_m_addr", bus.m_addr, 32'h8000_3002);
    check("post_rst_m_size", 32'(bus.m_size), 32'd1);
    bus.m_addr_ok = 1'b1;
    step();
    bus.m_addr_ok = 1'b0; bus.d_valid = 1'b0;
    bus.m_data_ok = 1'b1; bus.m_data = 32'h0000_BEEF;
    settle();
    check("post_rst_d_data_ok", 32'(bus.d_data_ok), 32'd1);
    check("post_rst_d_data", bus.d_data, 32'h0000_BEEF);
    step();
    bus.m_data_ok = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Two-to-one arbiter that shares the single memory bus between the fetch stage's instruction request port and the memory stage's data request port. It accepts one transaction at a time and holds the grant from address phase through `data_ok`. Data requests win by default; an anti-starvation counter forces an instruction grant after a bounded run of data grants. It sits between the pipeline's ibus/dbus request ports and the cache/uncached bus bridge.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive contested data grants after which instruction wins the next contested arbitration; legal range 1..15.

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `resetn` in 1: asynchronous, active-low reset.
- `i_valid` in 1: instruction request; held stable with `i_addr` until `i_addr_ok`.
- `i_addr` in 32: instruction address.
- `i_addr_ok` out 1: instruction address accepted.
- `i_data_ok` out 1: instruction data returned.
- `i_data` out 32: instruction word; valid when `i_data_ok`.
- `d_valid` in 1: data request; held stable with all `d_*` fields until `d_addr_ok`.
- `d_addr` in 32, `d_size` in 2, `d_strobe` in 4, `d_wdata` in 32: data request fields; `d_strobe != 0` means write.
- `d_addr_ok` out 1, `d_data_ok` out 1, `d_data` out 32: data-side responses.
- `m_valid` out 1: downstream request valid.
- `m_is_instr` out 1: 1 = current downstream request is an instruction fetch.
- `m_addr` out 32, `m_size` out 2, `m_strobe` out 4, `m_wdata` out 32: downstream request fields.
- `m_addr_ok` in 1, `m_data_ok` in 1, `m_data` in 32: downstream responses.

## Operation
- FSM states: IDLE, ADDR_I, ADDR_D, DATA_I, DATA_D.
- IDLE: evaluate requests each cycle; next state:
  - only `d_valid` -> ADDR_D; only `i_valid` -> ADDR_I;
  - both: ADDR_I if `starve_cnt == STARVE_LIMIT`, else ADDR_D.
  - neither: stay IDLE.
- ADDR_x: `m_valid=1`, `m_*` fields = granted requester's inputs (combinational pass-through, instruction: `m_size=2'b10`, `m_strobe=0`, `m_wdata=0`); `x_addr_ok = m_addr_ok`. On `m_addr_ok`: -> DATA_x; if `m_data_ok` also set same cycle -> IDLE.
- DATA_x: `m_valid=0`; `x_data_ok = m_data_ok`; on `m_data_ok` -> IDLE.
- `i_data`/`d_data` = `m_data` for granted side, 0 for the other; `x_data_ok` asserted in ADDR_x or DATA_x only.
- `starve_cnt` (4 bits): on IDLE->ADDR_D with `i_valid=1`, increment (saturate at `STARVE_LIMIT`); on IDLE->ADDR_I, clear to 0; uncontested data grants leave it unchanged.
- `m_is_instr` = 1 in ADDR_I/DATA_I, else 0.
- `m_data_ok` in IDLE is ignored; no response forwarded.
- Grant never changes while in ADDR_x/DATA_x, regardless of requester valid changes.

## Timing
- Reset (async, `resetn=0`): state IDLE, `starve_cnt=0`; all outputs 0 immediately and while held; a transaction in flight is abandoned, and late `m_data_ok` after release is ignored.
- Arbitration latency: request first seen at cycle N in IDLE -> `m_valid=1` at cycle N+1.
- `x_addr_ok` is the same cycle as `m_addr_ok`; `x_data_ok` is the same cycle as `m_data_ok`; no buffering of data.
- Back-to-back: after `m_data_ok` at cycle N, state IDLE at N+1; next `m_valid` at N+2 at the earliest.
- One outstanding downstream transaction maximum.

## Test plan
- Lone fetch: `i_valid=1, i_addr=0xBFC00000`, `m_addr_ok` on first ADDR cycle, `m_data_ok` 2 cycles later with `m_data=0x3C1D0001` -> `m_is_instr=1`, `i_addr_ok` 1 cycle, `i_data_ok` pulse with `i_data=0x3C1D0001`, `d_*` outputs 0.
- Contested: `i_valid` and `d_valid` (`d_addr=0x80001000, d_strobe=4'hF, d_wdata=0xDEADBEEF`) both high in IDLE -> data granted first with `m_strobe=4'hF`, instruction granted after data `m_data_ok`.
- Starvation, `STARVE_LIMIT=4`: `i_valid` and `d_valid` held high continuously -> grant order D,D,D,D,I,D,D,D,D,I.
- Same-cycle `m_addr_ok` and `m_data_ok` in ADDR_D -> `d_addr_ok` and `d_data_ok` both pulse that cycle, state IDLE next cycle.
- Stall: `m_addr_ok` held low 5 cycles in ADDR_I while `d_valid` rises -> `m_addr`/`m_is_instr` unchanged and `d_addr_ok` stays 0 throughout.
- Reset mid-op: `resetn` low during DATA_D -> outputs 0 in that cycle; after release, `m_data_ok=1` in IDLE produces no `d_data_ok`; a new request is served normally.
